// File: rtl/ifq_fifo_if.sv
// Handshake and data bundle between the fetch-queue controller, the
// instruction fetch queue storage and decode.
//   master : controller side, drives push/pop/bypass/flush and write data
//   slave  : queue side, returns dout/dout_pc/dout_valid, count and status
interface ifq_fifo_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              push_fifo;
    logic              pop_fifo;
    logic              bypass;
    logic              flush;
    logic [DATA_W-1:0] din;
    logic [PC_W-1:0]   din_pc;
    logic [DATA_W-1:0] dout;
    logic [PC_W-1:0]   dout_pc;
    logic              dout_valid;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push_fifo, pop_fifo, bypass, flush, din, din_pc,
        input  dout, dout_pc, dout_valid, fifo_empty, fifo_full, count,
               overflow, underflow
    );

    modport slave (
        input  push_fifo, pop_fifo, bypass, flush, din, din_pc,
        output dout, dout_pc, dout_valid, fifo_empty, fifo_full, count,
               overflow, underflow
    );
endinterface

// File: rtl/ifq_fifo.sv
// Instruction fetch queue storage: circular buffer of instruction words
// tagged with their PCs, one-cycle registered read, empty-queue bypass,
// single-cycle branch flush and sticky overflow/underflow flags.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-low reset
//   bus   : ifq_fifo_if.slave (push/pop/bypass/flush in, dout/status out)
module ifq_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    ifq_fifo_if.slave  bus
);
    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned ENTRY_W = PC_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_next_c;
    logic [DATA_W-1:0]  dout_q;
    logic [PC_W-1:0]    dout_pc_q;
    logic               valid_q;
    logic               empty_q;
    logic               full_q;
    logic               ovf_q;
    logic               unf_q;

    logic empty_c;
    logic full_c;
    logic bypass_c;
    logic pop_acc_c;
    logic push_acc_c;
    logic ovf_c;
    logic unf_c;

    // Accept/reject decisions; occupancy is judged from the count register only
    always_comb begin
        empty_c    = (cnt_q == '0);
        full_c     = (cnt_q == FULL_CNT);
        bypass_c   = empty_c && bus.pop_fifo && bus.push_fifo && bus.bypass;
        pop_acc_c  = bus.pop_fifo && !empty_c;
        // A pop frees the slot a full-queue push needs in the same cycle
        push_acc_c = bus.push_fifo && !bypass_c && (!full_c || pop_acc_c);
        ovf_c      = bus.push_fifo && full_c && !pop_acc_c;
        unf_c      = bus.pop_fifo && empty_c && !bypass_c;
        cnt_next_c = cnt_q;
        if (push_acc_c && !pop_acc_c) begin
            cnt_next_c = cnt_q + CNT_W'(1);
        end else if (pop_acc_c && !push_acc_c) begin
            cnt_next_c = cnt_q - CNT_W'(1);
        end
    end

    // Storage array: written only on an accepted push, never reset
    always_ff @(posedge clk) begin
        if (reset && !bus.flush && push_acc_c) begin
            mem[wr_ptr] <= {bus.din_pc, bus.din};
        end
    end

    // Pointers, count, output register and sticky flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            dout_pc_q <= '0;
            valid_q   <= 1'b0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (push_acc_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            // When full, wr_ptr == rd_ptr: the read sees the old entry
            if (pop_acc_c) begin
                {dout_pc_q, dout_q} <= mem[rd_ptr];
                rd_ptr              <= rd_ptr + ADDR_W'(1);
            end else if (bypass_c) begin
                {dout_pc_q, dout_q} <= {bus.din_pc, bus.din};
            end
            valid_q <= pop_acc_c || bypass_c;
            cnt_q   <= cnt_next_c;
            empty_q <= (cnt_next_c == '0);
            full_q  <= (cnt_next_c == FULL_CNT);
            if (ovf_c) begin
                ovf_q <= 1'b1;
            end
            if (unf_c) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_pc    = dout_pc_q;
    assign bus.dout_valid = valid_q;
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_full  = full_q;
    assign bus.count      = cnt_q;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;
endmodule

// File: tb/tb_ifq_fifo.sv
// Self-checking bench for ifq_fifo: directed scenarios followed by random
// traffic, compared every cycle against a queue-based reference model.
module tb_ifq_fifo;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned DEPTH  = 16;

    logic clk;
    logic reset;

    ifq_fifo_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    ifq_fifo #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] q[$];
    logic [31:0] m_dout;
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_ovf;
    logic        m_unf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic rs, input logic ps, input logic pp,
                         input logic bp, input logic fl,
                         input logic [31:0] d, input logic [31:0] p);
        logic popped;
        logic byp;
        if (!rs) begin
            q.delete();
            m_dout = '0; m_pc = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (fl) begin
            q.delete();
            m_valid = 1'b0;
        end else begin
            byp    = pp && ps && bp && (q.size() == 0);
            popped = pp && (q.size() > 0);
            if (popped) {m_pc, m_dout} = q.pop_front();
            if (byp) begin
                {m_pc, m_dout} = {p, d};
            end else if (ps) begin
                if (q.size() < DEPTH) q.push_back({p, d});
                else m_ovf = 1'b1;
            end
            if (pp && !popped && !byp) m_unf = 1'b1;
            m_valid = popped || byp;
        end
    endtask

    task automatic step(input logic rs, input logic ps, input logic pp,
                        input logic bp, input logic fl,
                        input logic [31:0] d, input logic [31:0] p);
        reset         = rs;
        bus.push_fifo = ps;
        bus.pop_fifo  = pp;
        bus.bypass    = bp;
        bus.flush     = fl;
        bus.din       = d;
        bus.din_pc    = p;
        model(rs, ps, pp, bp, fl, d, p);
        @(posedge clk);
        #1;
        chk("dout_valid", 64'(bus.dout_valid), 64'(m_valid));
        chk("dout",       64'(bus.dout),       64'(m_dout));
        chk("dout_pc",    64'(bus.dout_pc),    64'(m_pc));
        chk("count",      64'(bus.count),      64'(q.size()));
        chk("fifo_empty", 64'(bus.fifo_empty), 64'(q.size() == 0));
        chk("fifo_full",  64'(bus.fifo_full),  64'(q.size() == DEPTH));
        chk("overflow",   64'(bus.overflow),   64'(m_ovf));
        chk("underflow",  64'(bus.underflow),  64'(m_unf));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        bus.push_fifo = 1'b0; bus.pop_fifo = 1'b0; bus.bypass = 1'b0;
        bus.flush = 1'b0; bus.din = '0; bus.din_pc = '0;
        q.delete();
        m_dout = '0; m_pc = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset then idle
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) idle();
        chk("reset_empty", 64'(bus.fifo_empty), 64'(1));
        chk("reset_count", 64'(bus.count), 64'(0));

        // Push 4, pop 4 back to back
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100 + 32'(i), 32'(4 * i));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            chk("seq_dout", 64'(bus.dout), 64'(32'h100 + 32'(i)));
            chk("seq_pc",   64'(bus.dout_pc), 64'(4 * i));
        end
        idle();

        // Fill, overflow, push+pop while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200 + 32'(i), 32'h1000 + 32'(4 * i));
        chk("fill_full", 64'(bus.fifo_full), 64'(1));
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hBAD, 32'hBAD);
        chk("ovf_set", 64'(bus.overflow), 64'(1));
        chk("ovf_count", 64'(bus.count), 64'(DEPTH));
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h2000);
        chk("full_pushpop_dout", 64'(bus.dout), 64'(32'h200));
        chk("full_pushpop_count", 64'(bus.count), 64'(DEPTH));
        while (q.size() > 0) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();

        // Streaming across pointer wrap at occupancy 3
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h400 + 32'(i), 32'h3000 + 32'(4 * i));
        for (int i = 3; i < 40; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400 + 32'(i), 32'h3000 + 32'(4 * i));
            chk("wrap_order", 64'(bus.dout), 64'(32'h400 + 32'(i - 3)));
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();

        // Bypass on empty, then same without bypass
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD, 32'h40);
        chk("bypass_dout", 64'(bus.dout), 64'(32'hDEAD));
        chk("bypass_pc", 64'(bus.dout_pc), 64'(32'h40));
        chk("bypass_count", 64'(bus.count), 64'(0));
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD, 32'h40);
        chk("nobyp_valid", 64'(bus.dout_valid), 64'(0));
        chk("nobyp_unf", 64'(bus.underflow), 64'(1));
        chk("nobyp_count", 64'(bus.count), 64'(1));

        // Flush at count 6 with push and pop asserted
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500 + 32'(i), 32'h4000 + 32'(i));
        chk("preflush_count", 64'(bus.count), 64'(6));
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h999, 32'h999);
        chk("flush_count", 64'(bus.count), 64'(0));
        chk("flush_valid", 64'(bus.dout_valid), 64'(0));
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h50);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("postflush_dout", 64'(bus.dout), 64'(32'h55));

        // Reset mid-burst, first push after reset lands first out
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h600 + 32'(i), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 32'h70);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("postreset_dout", 64'(bus.dout), 64'(32'h77));

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic rs, ps, pp, bp, fl;
            rs = ($urandom_range(0, 199) != 0);
            ps = ($urandom_range(0, 99) < 55);
            pp = ($urandom_range(0, 99) < 50);
            bp = ($urandom_range(0, 99) < 30);
            fl = ($urandom_range(0, 99) < 3);
            step(rs, ps, pp, bp, fl, $urandom(), $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifq_fifo.md
Name: ifq_fifo

Overview:
- Instruction fetch queue storage: circular buffer of instruction words with their PCs.
- Sits directly downstream of the fetch-queue controller and instruction cache, and upstream of decode.
- The controller drives push_fifo, pop_fifo and bypass; this block returns fifo_empty and fifo_full to it.
- A branch flush empties the queue in one cycle.

Parameters:
- DATA_W, 32, instruction word width
- PC_W, 32, width of the PC tag stored with each entry
- DEPTH, 16, number of entries; power of two, >= 4
- ADDR_W, $clog2(DEPTH), pointer width

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset
- push_fifo  input  1  write din/din_pc this cycle
- pop_fifo  input  1  read request from decode
- bypass  input  1  allow push data straight to the output when the queue is empty
- flush  input  1  branch_valid from the branch unit; discard all contents
- din  input  DATA_W  instruction from the cache
- din_pc  input  PC_W  PC of din
- dout  output  DATA_W  registered instruction to decode
- dout_pc  output  PC_W  registered PC of dout
- dout_valid  output  1  dout/dout_pc hold a freshly popped entry this cycle
- fifo_empty  output  1  count == 0
- fifo_full  output  1  count == DEPTH
- count  output  ADDR_W+1  number of stored entries
- overflow  output  1  sticky: push rejected while full
- underflow  output  1  sticky: pop rejected while empty

Behaviour:
- Reset (reset==0 at a clk edge):
  - wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_pc=0.
  - dout_valid=0, overflow=0, underflow=0, fifo_empty=1, fifo_full=0.
  - Storage array is not reset.
  - Reset mid-burst discards everything; the first push after reset lands in entry 0.
- Priority per cycle: reset > flush > push/pop.
- Flush:
  - wr_ptr=0, rd_ptr=0, count=0, dout_valid=0 next cycle.
  - A push or pop in the same cycle is ignored.
  - Sticky flags are unchanged; only reset clears them.
- Push accepted when push_fifo=1 and either count<DEPTH, or count==DEPTH with an accepted pop in the same cycle.
  - Accepted push: mem[wr_ptr]<={din_pc,din}; wr_ptr wraps modulo DEPTH.
  - Push while full with no pop: data dropped, overflow<=1, pointers unchanged.
- Pop accepted when pop_fifo=1 and count>0:
  - {dout_pc,dout}<=mem[rd_ptr]; dout_valid=1 next cycle; rd_ptr wraps modulo DEPTH.
  - Read latency is 1 cycle from pop to dout_valid.
- Bypass: when count==0, pop_fifo=1, push_fifo=1 and bypass=1:
  - {dout_pc,dout}<={din_pc,din}; dout_valid=1 next cycle.
  - Nothing is written; pointers and count are unchanged.
- Empty pop without the bypass condition: dout_valid=0 next cycle, underflow<=1, dout/dout_pc hold their previous values.
- When no pop is accepted: dout_valid=0 next cycle, dout/dout_pc hold their previous values.
- count next value:
  - +1 for an accepted push only.
  - -1 for an accepted pop only.
  - Unchanged for push+pop or bypass.
- fifo_empty, fifo_full and count are registered (derived from the count register); no combinational path from inputs.
- Pointer wrap: ADDR_W-bit pointers roll DEPTH-1 -> 0 with no gap.
- Full/empty are decided by count, never by pointer equality alone.
- No X propagation: dout is driven only from written entries or din.

Test Plan:
- Reset then idle 3 cycles -> fifo_empty=1, fifo_full=0, count=0, dout_valid=0, overflow=0, underflow=0.
- Push 4 words 0x100..0x103 with PCs 0x0..0xC, then pop 4 in consecutive cycles -> dout_valid=1 for 4 cycles, dout=0x100,0x101,0x102,0x103 with dout_pc=0x0,0x4,0x8,0xC; ends with count=0, fifo_empty=1.
- Push 16 words (fill) -> fifo_full=1, count=16.
  - 17th push alone -> dropped, overflow=1, count=16.
  - Then push+pop in the same cycle -> count stays 16, dout = first word.
- Wrap-around: push/pop streaming 40 words at count≈3 -> output order matches input order exactly across pointer wrap; no dout_valid gaps.
- Empty with push+pop+bypass=1, din=0xDEAD, din_pc=0x40 -> next cycle dout=0xDEAD, dout_pc=0x40, dout_valid=1, count=0.
  - Same stimulus with bypass=0 -> dout_valid=0, underflow=1, count=1.
- With count=6, assert flush together with push_fifo and pop_fifo -> next cycle count=0, fifo_empty=1, dout_valid=0.
  - Next push of 0x55 then pop -> dout=0x55.
